piso_vr: RTL and testbench

Parametrised parallel-in/serial-out width down-converter between two valid/ready streams, generalising the fixed 8-to-2 PISO. One IN_W word is accepted and emitted as IN_W/OUT_W beats of OUT_W bits each, in a selectable bit order, with a last flag on the final beat. A one-word holding buffer lets the next word be accepted while the current one is still draining, so back-to-back words stream with no bubble. The block sits between a wide producer and a narrow link or serializer.

---
 rtl/piso_vr_if.sv | 18 +
 rtl/piso_vr.sv | 121 ++++++++++++
 tb/tb_piso_vr.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_vr_if.sv
// Valid/ready stream bundle shared by the wide input side and the narrow
// output side of the width down-converter.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The producer holds data and valid stable until that edge.
// The consumer may raise or lower ready at any time.
interface valid_ready_std_if #(
    parameter int DATAWIDTH = 8
);
    logic [DATAWIDTH-1:0] data;
    logic                 valid;
    logic                 ready;

    // Consumer side: takes data/valid, returns ready.
    modport in  (input data, input valid, output ready);
    // Producer side: drives data/valid, observes ready.
    modport out (output data, output valid, input ready);
endinterface

// File: rtl/piso_vr.sv
// Parallel-in/serial-out width down-converter. Each IN_W word accepted on din
// is emitted on dout as IN_W/OUT_W beats, most or least significant slice
// first, with last marking the final beat. A one-word holding register lets
// the next word arrive while the current one drains, so words stream without
// a bubble between them.
module piso_vr #(
    parameter int IN_W      = 8,
    parameter int OUT_W     = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    valid_ready_std_if.in        din,
    valid_ready_std_if.out       dout,
    output logic                 last
);

    localparam int RATIO = IN_W / OUT_W;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    // Reject widths that do not split into at least two whole beats.
    if (((IN_W % OUT_W) != 0) || (RATIO < 2)) begin : g_bad_params
        $error("piso_vr: IN_W must be a multiple of OUT_W with IN_W/OUT_W >= 2");
    end

    // Buffer occupancy: EMPTY = nothing held, ONE = shift register loaded,
    // TWO = shift register and holding register both loaded.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    occ_e             occ_q, occ_d;
    logic [IN_W-1:0]  s_q, s_d;
    logic [IN_W-1:0]  h_q, h_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             in_fire;
    logic             out_fire;
    logic             final_fire;
    logic [OUT_W-1:0] slice [RATIO];
    logic [CNT_W-1:0] slice_idx;

    // Ready depends only on registered occupancy, never on dout.ready.
    assign din.ready  = (occ_q != OCC_TWO);
    assign dout.valid = (occ_q != OCC_EMPTY);

    assign in_fire    = din.valid && din.ready;
    assign out_fire   = dout.valid && dout.ready;
    assign final_fire = out_fire && (cnt_q == LAST_CNT);

    // Split the shift register into beat-sized slices, slice 0 at the LSBs.
    for (genvar i = 0; i < RATIO; i++) begin : g_slice
        assign slice[i] = s_q[i*OUT_W +: OUT_W];
    end

    // Map the beat counter onto a slice according to the chosen bit order.
    always_comb begin
        slice_idx = cnt_q;
        if (MSB_FIRST) begin
            slice_idx = LAST_CNT - cnt_q;
        end
    end

    assign dout.data = slice[slice_idx];
    assign last      = dout.valid && (cnt_q == LAST_CNT);

    // Next-state: beat counting, refill of S on the final beat, and capture of
    // incoming words into S (when empty) or H (when S is busy).
    always_comb begin
        occ_d = occ_q;
        s_d   = s_q;
        h_d   = h_q;
        cnt_d = cnt_q;

        if (final_fire) begin
            cnt_d = '0;
            if (occ_q == OCC_TWO) begin
                // din.ready is low here, so no input can land this cycle.
                s_d   = h_q;
                occ_d = OCC_ONE;
            end else if (in_fire) begin
                s_d   = din.data;
            end else begin
                occ_d = OCC_EMPTY;
            end
        end else begin
            if (out_fire) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (in_fire) begin
                if (occ_q == OCC_EMPTY) begin
                    s_d   = din.data;
                    cnt_d = '0;
                    occ_d = OCC_ONE;
                end else begin
                    h_d   = din.data;
                    occ_d = OCC_TWO;
                end
            end
        end
    end

    // State registers; reset discards any held words at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= OCC_EMPTY;
            s_q   <= '0;
            h_q   <= '0;
            cnt_q <= '0;
        end else begin
            occ_q <= occ_d;
            s_q   <= s_d;
            h_q   <= h_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_piso_vr.sv
// Bench for piso_vr: three instances (8->2 MSB first, 8->2 LSB first,
// 12->4 MSB first) checked every cycle against a queue-of-beats model, plus
// literal beat sequences that pin the model.
module tb_piso_vr;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    valid_ready_std_if #(.DATAWIDTH(8))  in0 ();
    valid_ready_std_if #(.DATAWIDTH(2))  out0 ();
    valid_ready_std_if #(.DATAWIDTH(8))  in1 ();
    valid_ready_std_if #(.DATAWIDTH(2))  out1 ();
    valid_ready_std_if #(.DATAWIDTH(12)) in2 ();
    valid_ready_std_if #(.DATAWIDTH(4))  out2 ();
    logic last0, last1, last2;

    piso_vr #(.IN_W(8),  .OUT_W(2), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .din(in0), .dout(out0), .last(last0));
    piso_vr #(.IN_W(8),  .OUT_W(2), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(in1), .dout(out1), .last(last1));
    piso_vr #(.IN_W(12), .OUT_W(4), .MSB_FIRST(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .din(in2), .dout(out2), .last(last2));

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    // Expected beats per instance, {last, data} with data zero-extended to 4 bits.
    logic [4:0] exp_q0[$], exp_q1[$], exp_q2[$];
    // Beats actually transferred, for the literal sequence checks.
    logic [4:0] log0[$], log1[$], log2[$];
    int beat_cyc[$];
    bit stream_mon = 0;
    int low_run = 0;
    int low_max = 0;
    bit bp_mon = 0;
    bit saw_stall = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model of one instance for one cycle: compare outputs to the head of the
    // expected queue, then apply the handshakes that the coming edge completes.
    task automatic model_step(input int id, input int in_w, input int out_w, input bit msb,
                              input logic ov, input logic ordy, input logic olast,
                              input logic [3:0] odata, input logic iv, input logic irdy,
                              input logic [11:0] idata);
        logic [4:0] q[$];
        logic [4:0] lg[$];
        int ratio, outstanding, idx, d;
        case (id)
            0: begin q = exp_q0; lg = log0; end
            1: begin q = exp_q1; lg = log1; end
            default: begin q = exp_q2; lg = log2; end
        endcase
        ratio = in_w / out_w;
        if (!rst_n) begin
            chk($sformatf("reset_outputs%0d", id), {ov, olast, irdy, odata},
                {1'b0, 1'b0, 1'b1, 4'h0});
            q.delete();
        end else begin
            // A word occupies S or H until its last beat leaves.
            outstanding = (q.size() + ratio - 1) / ratio;
            if (q.size() == 0) begin
                chk($sformatf("idle_valid_last%0d", id), {ov, olast}, 2'b00);
            end else begin
                chk($sformatf("beat%0d", id), {ov, olast, odata}, {1'b1, q[0]});
            end
            chk($sformatf("din_ready%0d", id), irdy, (outstanding < 2) ? 1 : 0);
            if (ov && ordy && q.size() > 0) begin
                void'(q.pop_front());
                lg.push_back({olast, odata});
                if (id == 0) beat_cyc.push_back(cyc);
            end
            if (iv && irdy) begin
                for (int b = 0; b < ratio; b++) begin
                    idx = msb ? (ratio - 1 - b) : b;
                    d = (int'(idata) >> (idx * out_w)) & ((1 << out_w) - 1);
                    q.push_back({(b == ratio - 1), 4'(d)});
                end
            end
        end
        case (id)
            0: begin exp_q0 = q; log0 = lg; end
            1: begin exp_q1 = q; log1 = lg; end
            default: begin exp_q2 = q; log2 = lg; end
        endcase
    endtask

    // Single compare process: outputs are sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (stream_mon) begin
            if (!in0.ready) low_run++;
            else low_run = 0;
            if (low_run > low_max) low_max = low_run;
        end
        if (bp_mon && in0.valid && !in0.ready) saw_stall = 1;
        model_step(0, 8, 2, 1'b1, out0.valid, out0.ready, last0, {2'b0, out0.data},
                   in0.valid, in0.ready, {4'b0, in0.data});
        model_step(1, 8, 2, 1'b0, out1.valid, out1.ready, last1, {2'b0, out1.data},
                   in1.valid, in1.ready, {4'b0, in1.data});
        model_step(2, 12, 4, 1'b1, out2.valid, out2.ready, last2, out2.data,
                   in2.valid, in2.ready, in2.data);
    end

    // ---------------- driver tasks ----------------
    task automatic set_in(input int id, input logic v, input logic [11:0] data);
        case (id)
            0: begin in0.valid = v; in0.data = data[7:0]; end
            1: begin in1.valid = v; in1.data = data[7:0]; end
            default: begin in2.valid = v; in2.data = data; end
        endcase
    endtask

    task automatic set_rdy(input int id, input logic r);
        case (id)
            0: out0.ready = r;
            1: out1.ready = r;
            default: out2.ready = r;
        endcase
    endtask

    function automatic logic get_iready(input int id);
        case (id)
            0: return in0.ready;
            1: return in1.ready;
            default: return in2.ready;
        endcase
    endfunction

    function automatic int qsize(input int id);
        case (id)
            0: return exp_q0.size();
            1: return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    // Offer one word; returns just after the accepting edge with valid dropped.
    task automatic push_word(input int id, input logic [11:0] word);
        int n = 0;
        bit done = 0;
        set_in(id, 1'b1, word);
        while (!done) begin
            @(negedge clk);
            if (get_iready(id)) begin
                @(posedge clk);
                #1;
                done = 1;
            end else begin
                @(posedge clk);
                #1;
                n++;
                if (n > 300) begin
                    chk($sformatf("accept_timeout%0d", id), 0, 1);
                    done = 1;
                end
            end
        end
        set_in(id, 1'b0, 12'h0);
    endtask

    task automatic wait_drain(input int id);
        int n = 0;
        while (qsize(id) != 0 && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("drain%0d", id), qsize(id), 0);
    endtask

    task automatic check_log(input string name, input logic [4:0] got[$], input logic [4:0] want[$]);
        chk({name, "_count"}, got.size(), want.size());
        for (int i = 0; i < want.size() && i < got.size(); i++) begin
            chk($sformatf("%s_beat%0d", name, i), got[i], want[i]);
        end
    endtask

    task automatic rand_words(input int id, input int n);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            push_word(id, 12'($urandom));
        end
    endtask

    // ---------------- stimulus ----------------
    logic [4:0] want[$];
    bit rand_done;

    initial begin
        for (int i = 0; i < 3; i++) begin
            set_in(i, 1'b0, 12'h0);
            set_rdy(i, 1'b0);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word on each instance, dout.ready held high.
        for (int i = 0; i < 3; i++) set_rdy(i, 1'b1);
        push_word(0, 12'h0CD);
        push_word(1, 12'h0CD);
        push_word(2, 12'hA5C);
        for (int i = 0; i < 3; i++) wait_drain(i);
        repeat (2) @(posedge clk);
        #1;
        want = '{5'b0_0011, 5'b0_0000, 5'b0_0011, 5'b1_0001};
        check_log("msb_cd", log0, want);
        want = '{5'b0_0001, 5'b0_0011, 5'b0_0000, 5'b1_0011};
        check_log("lsb_cd", log1, want);
        want = '{5'b0_1010, 5'b0_0101, 5'b1_1100};
        check_log("w12_a5c", log2, want);

        // Back-to-back stream of three words.
        log0.delete();
        beat_cyc.delete();
        stream_mon = 1;
        push_word(0, 12'h0CD);
        push_word(0, 12'h027);
        push_word(0, 12'h0AD);
        wait_drain(0);
        stream_mon = 0;
        want = '{5'b0_0011, 5'b0_0000, 5'b0_0011, 5'b1_0001,
                 5'b0_0000, 5'b0_0010, 5'b0_0001, 5'b1_0011,
                 5'b0_0010, 5'b0_0010, 5'b0_0011, 5'b1_0001};
        check_log("stream", log0, want);
        if (beat_cyc.size() == 12) chk("stream_no_bubble", beat_cyc[11] - beat_cyc[0], 11);
        else chk("stream_beat_cycles", beat_cyc.size(), 12);
        // H fills one beat into a word and frees on that word's final beat.
        chk("stream_ready_low_run", low_max, 3);

        // Backpressure mid-word and on the final beat with two more words offered.
        log0.delete();
        set_rdy(0, 1'b0);
        push_word(0, 12'h0B4);
        bp_mon = 1;
        fork
            begin
                push_word(0, 12'h069);
                push_word(0, 12'h0F2);
            end
            begin
                want = '{5'd1, 5'd0, 5'd0, 5'd0, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 5'd1};
                for (int i = 0; i < want.size(); i++) begin
                    set_rdy(0, want[i][0]);
                    @(posedge clk);
                    #1;
                end
            end
        join
        bp_mon = 0;
        wait_drain(0);
        chk("bp_saw_din_stall", saw_stall, 1);
        chk("bp_beat_count", log0.size(), 12);

        // Reset with S and H both full, then confirm nothing stale comes out.
        set_rdy(0, 1'b0);
        push_word(0, 12'h0E1);
        push_word(0, 12'h01E);
        @(negedge clk);
        chk("full_din_ready", in0.ready, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        log0.delete();
        set_rdy(0, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        chk("post_reset_stale_beats", log0.size(), 0);

        // Randomised traffic on all three instances with random backpressure.
        rand_done = 0;
        fork
            begin
                fork
                    rand_words(0, 25);
                    rand_words(1, 25);
                    rand_words(2, 25);
                join
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    for (int i = 0; i < 3; i++) set_rdy(i, ($urandom_range(0, 3) != 0));
                    @(posedge clk);
                    #1;
                end
            end
        join
        for (int i = 0; i < 3; i++) set_rdy(i, 1'b1);
        for (int i = 0; i < 3; i++) wait_drain(i);
        repeat (3) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
